// File: rtl/qspi_target.sv
// qspi_target: QSPI responder acting as the memory-device end of the qspi
// initiator link (bench/on-FPGA stand-in for an external flash or PSRAM).
// It decodes 0x38 (quad write), 0xEB (quad read) and 0x35 (enter quad) in
// SPI or quad command mode. The device is backed by an internal byte RAM
// that has a backdoor port for preload and inspection.
//
// Optional feature: define QSPI_TARGET_EXIT_QUAD_EN to accept 0xF5 in quad
// mode as "exit quad". Without it, 0xF5 is an unknown command and only
// reset leaves quad mode.
//
// Ports:
//   clk, reset        system clock, synchronous active-high reset
//   i_cs_n            chip select, active low
//   i_io_in[3:0]      sampled IO lines (io_in[0] = serial data in SPI mode)
//   o_io_out[3:0]     driven IO data (registered)
//   o_io_oe[3:0]      per-line output enable (registered)
//   i_wait_cycles     read dummy cycles, 0 treated as 1
//   o_quad_mode       quad command mode active
//   o_busy            transaction in progress
//   i_bd_we/i_bd_addr/i_bd_wdata  backdoor write (wins RAM port collisions)
//   o_bd_rdata        backdoor read data, 1-cycle latency
module qspi_target #(
    parameter int DEPTH = 256,
    parameter int AW    = 24
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     i_cs_n,
    input  logic [3:0]               i_io_in,
    output logic [3:0]               o_io_out,
    output logic [3:0]               o_io_oe,
    input  logic [4:0]               i_wait_cycles,
    output logic                     o_quad_mode,
    output logic                     o_busy,
    input  logic                     i_bd_we,
    input  logic [$clog2(DEPTH)-1:0] i_bd_addr,
    input  logic [7:0]               i_bd_wdata,
    output logic [7:0]               o_bd_rdata
);
    localparam int ABITS = $clog2(DEPTH);
    localparam int ANIBS = AW / 4;

    localparam logic [7:0] CMD_QWRITE     = 8'h38;
    localparam logic [7:0] CMD_QREAD      = 8'hEB;
    localparam logic [7:0] CMD_ENTER_QUAD = 8'h35;
`ifdef QSPI_TARGET_EXIT_QUAD_EN
    localparam logic [7:0] CMD_EXIT_QUAD  = 8'hF5;
`endif

    typedef enum logic [2:0] {
        IDLE, CMD, ADDR, WDATA, DUMMY, RDATA, IGNORE
    } state_t;

    state_t           r_state;
    logic [6:0]       r_cmd_sh;
    logic [4:0]       r_cnt;
    logic             r_nib;
    logic [3:0]       r_hi;
    logic             r_is_read;
    logic [ABITS-1:0] r_addr;
    logic [3:0]       r_io_out;
    logic [3:0]       r_io_oe;
    logic             r_quad;
    logic             r_busy;
    logic [7:0]       r_bd_rdata;
    logic [7:0]       r_mem [DEPTH];

    logic [7:0] w_cmd;
    logic       w_cmd_last;
    logic [4:0] w_wait_last;
    logic [7:0] w_rd_byte;
    logic       w_pwe;

    // Command shift: one bit per cycle in SPI mode, one nibble in quad mode.
    assign w_cmd       = r_quad ? {r_cmd_sh[3:0], i_io_in} : {r_cmd_sh, i_io_in[0]};
    assign w_cmd_last  = r_quad ? (r_cnt == 5'd1) : (r_cnt == 5'd7);
    // Dummy window length is max(wait_cycles,1); r_cnt counts from 0.
    assign w_wait_last = (i_wait_cycles == 5'd0) ? 5'd0 : i_wait_cycles - 5'd1;
    assign w_rd_byte   = r_mem[r_addr];
    // A protocol byte is complete on the low nibble of a WDATA pair.
    assign w_pwe       = !reset && !i_cs_n && (r_state == WDATA) && r_nib;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state   <= IDLE;
            r_io_out  <= 4'h0;
            r_io_oe   <= 4'h0;
            r_quad    <= 1'b0;
            r_busy    <= 1'b0;
            r_cnt     <= 5'd0;
            r_nib     <= 1'b0;
            r_is_read <= 1'b0;
        end else if (i_cs_n) begin
            // Deselect aborts whatever is in flight; quad mode is sticky.
            r_state <= IDLE;
            r_io_oe <= 4'h0;
            r_busy  <= 1'b0;
        end else begin
            r_busy <= 1'b1;
            case (r_state)
                IDLE: begin
                    // This first selected cycle already carries command data.
                    r_cmd_sh <= r_quad ? {3'b000, i_io_in} : {6'b000000, i_io_in[0]};
                    r_cnt    <= 5'd1;
                    r_state  <= CMD;
                end
                CMD: begin
                    r_cmd_sh <= w_cmd[6:0];
                    if (w_cmd_last) begin
                        r_cnt <= 5'd0;
                        if (w_cmd == CMD_QWRITE) begin
                            r_is_read <= 1'b0;
                            r_state   <= ADDR;
                        end else if (w_cmd == CMD_QREAD) begin
                            r_is_read <= 1'b1;
                            r_state   <= ADDR;
                        end else if (w_cmd == CMD_ENTER_QUAD && !r_quad) begin
                            r_quad  <= 1'b1;
                            r_state <= IGNORE;
`ifdef QSPI_TARGET_EXIT_QUAD_EN
                        end else if (w_cmd == CMD_EXIT_QUAD && r_quad) begin
                            r_quad  <= 1'b0;
                            r_state <= IGNORE;
`endif
                        end else begin
                            r_state <= IGNORE;
                        end
                    end else begin
                        r_cnt <= r_cnt + 5'd1;
                    end
                end
                ADDR: begin
                    // High-order nibbles fall off the top: address mod DEPTH.
                    r_addr <= ABITS'({r_addr, i_io_in});
                    if (r_cnt == 5'(ANIBS - 1)) begin
                        r_cnt   <= 5'd0;
                        r_nib   <= 1'b0;
                        r_state <= r_is_read ? DUMMY : WDATA;
                    end else begin
                        r_cnt <= r_cnt + 5'd1;
                    end
                end
                WDATA: begin
                    if (!r_nib) begin
                        r_hi  <= i_io_in;
                        r_nib <= 1'b1;
                    end else begin
                        // Advance even if the backdoor stole the RAM port.
                        r_nib  <= 1'b0;
                        r_addr <= r_addr + 1'b1;
                    end
                end
                DUMMY: begin
                    if (r_cnt >= w_wait_last) begin
                        r_io_out <= w_rd_byte[7:4];
                        r_io_oe  <= 4'hF;
                        r_nib    <= 1'b1;
                        r_state  <= RDATA;
                    end else begin
                        r_cnt <= r_cnt + 5'd1;
                    end
                end
                RDATA: begin
                    if (r_nib) begin
                        r_io_out <= w_rd_byte[3:0];
                        r_nib    <= 1'b0;
                        r_addr   <= r_addr + 1'b1;
                    end else begin
                        r_io_out <= w_rd_byte[7:4];
                        r_nib    <= 1'b1;
                    end
                end
                IGNORE: begin
                    r_io_oe <= 4'h0;
                end
                default: begin
                    r_state <= IGNORE;
                end
            endcase
        end
    end

    // Single RAM write port: the backdoor wins a same-cycle collision.
    always_ff @(posedge clk) begin
        if (i_bd_we) begin
            r_mem[i_bd_addr] <= i_bd_wdata;
        end else if (w_pwe) begin
            r_mem[r_addr] <= {r_hi, i_io_in};
        end
        r_bd_rdata <= r_mem[i_bd_addr];
    end

    assign o_io_out    = r_io_out;
    assign o_io_oe     = r_io_oe;
    assign o_quad_mode = r_quad;
    assign o_busy      = r_busy;
    assign o_bd_rdata  = r_bd_rdata;

endmodule

// File: doc/qspi_target.md
Name: qspi_target

Overview:
- Synthesizable QSPI responder (memory-device end) for the qspi initiator link. Used as the on-FPGA/bench model of the external flash/PSRAM.
- Decodes SPI-mode and quad-mode commands 0x38 (quad write), 0xEB (quad read) and 0x35 (enter quad).
- Backed by an internal byte RAM, with a backdoor port for preload and inspection.
- Runs on the same clk as the initiator: one bit or nibble per clk while cs_n is low.

Parameters:
- DEPTH, 256: RAM size in bytes; power of 2.
- AW, 24: protocol address width in bits; fixed at 6 nibbles.

Ports:
- clk  in  1  system clock.
- reset  in  1  synchronous, active-high.
- cs_n  in  1  chip select, active low.
- io_in  in  4  sampled IO lines; io_in[0] carries serial data in SPI mode.
- io_out  out  4  driven IO data.
- io_oe  out  4  per-line output enable.
- wait_cycles  in  5  read dummy cycles between the last address nibble and the first data nibble; 0 is treated as 1.
- quad_mode  out  1  quad mode is active.
- busy  out  1  a transaction is in progress (cs_n low and not in IDLE).
- bd_we  in  1  backdoor write.
- bd_addr  in  $clog2(DEPTH)  backdoor address.
- bd_wdata  in  8  backdoor write data.
- bd_rdata  out  8  backdoor read data; 1-cycle latency.

Behaviour:
- Reset values: io_oe=0, io_out=0, quad_mode=0, busy=0, state=IDLE. RAM contents are not reset.
- All inputs are sampled on posedge clk. All outputs are registered.
- States: IDLE, CMD, ADDR, WDATA, DUMMY, RDATA, IGNORE.
- IDLE → CMD on the first cycle cs_n==0 is sampled. That cycle carries command bit 7 (SPI) or the high nibble (quad).
- CMD, SPI mode: 8 bits MSB first on io_in[0] (8 cycles).
- CMD, quad mode: 2 nibbles, high nibble first (2 cycles).
- Command decode on completion:
  - 0x38 → ADDR, write.
  - 0xEB → ADDR, read.
  - 0x35 (SPI mode only) → quad_mode=1 at the cycle after the 8th bit, then IGNORE.
  - 0x35 in quad mode, or any other value → IGNORE.
- ADDR: 6 nibbles, MSB first on io_in[3:0], in both modes.
  - Address is taken mod DEPTH.
  - Exit is WDATA (write) or DUMMY (read).
- WDATA:
  - Nibbles pair into bytes, high nibble first.
  - Each complete byte is written at the current address; address then increments and wraps at DEPTH.
  - An incomplete trailing nibble at cs_n rise is discarded.
- DUMMY:
  - io_oe stays 0 for max(wait_cycles,1) cycles after the last address nibble.
  - The RAM prefetch completes during this window.
- RDATA:
  - io_oe=4'hF. The first nibble is visible in cycle A+1+max(wait_cycles,1), where A is the cycle the last address nibble was sampled.
  - Order: high nibble then low nibble, one per cycle.
  - Address increments per byte and wraps at DEPTH.
  - Bytes stream continuously until cs_n rises.
- cs_n rise, any state:
  - Next cycle: state=IDLE, io_oe=0.
  - Partial command/address is discarded; no RAM write occurs.
  - quad_mode is unchanged.
- cs_n held low after IGNORE: stays in IGNORE, io_oe=0.
- cs_n must go high for at least 1 cycle between transactions. A new transaction starts only from IDLE.
- Backdoor port:
  - bd_we has priority over a protocol write to the same cycle's RAM port.
  - When they collide, the protocol write is dropped and the byte address still advances.
- Reset mid-transaction: immediate return to reset values; quad_mode clears.

Optional Feature:
- Macro: QSPI_TARGET_EXIT_QUAD_EN.
- Defined: command 0xF5 received in quad mode clears quad_mode the cycle after the 2nd nibble, then IGNORE.
- Undefined: 0xF5 is an unknown command (IGNORE). quad_mode leaves 1 only via reset.

Test Plan:
- Reset, then SPI 0x35 on io[0] (bits 0,0,1,1,0,1,0,1) → quad_mode=1 one cycle after the 8th bit; io_oe stays 0 throughout.
- Quad mode, write 0x3,0x8, address 000010, nibbles A,5,3,C → bd reads RAM[0x10]=0xA5 and RAM[0x11]=0x3C.
- Quad mode, wait_cycles=10, read 0xE,0xB, address 000010 → io_oe=0 for 10 cycles, then io_out sequence A,5,3,C with io_oe=F; io_oe drops the cycle after cs_n rises.
- SPI mode, 0xEB serial then address 0000FF, wait_cycles=0 → first nibble 1 cycle after address; bytes from RAM[0xFF] then RAM[0x00] (wrap).
- Write 3 nibbles 1,2,3 to address 20, then cs_n high → RAM[0x20]=0x12, RAM[0x21] unchanged; a following unknown command 0x9F → no outputs, busy=0 after cs_n rises.
- Reset asserted mid-RDATA → io_oe=0 and quad_mode=0 the next cycle. With the macro defined, quad-mode 0xF5 → quad_mode=0.
